// File: rtl/cp0_timer_int_if.sv
// rtl/cp0_timer_int_if.sv - MTC0 write bus into the CP0 timer/interrupt front end
//
// Purpose : carries committed MTC0 writes from the CP0 pipeline to cp0_timer_int.
// Signals : wr_en   - one-cycle commit strobe
//           wr_num  - CP0 register number
//           wr_sel  - CP0 select field
//           wr_data - write data
// Modports: master drives the write, slave (cp0_timer_int) receives it.
interface cp0_timer_int_if;
   logic        wr_en;
   logic [4:0]  wr_num;
   logic [2:0]  wr_sel;
   logic [31:0] wr_data;

   modport master (output wr_en, output wr_num, output wr_sel, output wr_data);
   modport slave  (input  wr_en, input  wr_num, input  wr_sel, input  wr_data);
endinterface

// File: rtl/cp0_timer_int.sv
// rtl/cp0_timer_int.sv - CP0 Count/Compare timer and hardware interrupt synchronizer
//
// Purpose : owns Count (reg 9) and Compare (reg 11), raises the sticky timer
//           interrupt, synchronizes the six hw interrupt lines and merges the
//           timer interrupt onto ext_int[TI_LINE] for Cause.IP[7:2].
// Ports   : clk     - core clock
//           rst     - synchronous active-high reset
//           wr      - MTC0 write bus (slave modport)
//           hw_int  - asynchronous level-sensitive interrupt requests
//           count   - current Count register
//           compare - current Compare register
//           ti      - sticky timer interrupt pending
//           ext_int - pending interrupt vector to CP0
module cp0_timer_int #(
   parameter int SYNC_STAGES = 2,
   parameter int COUNT_DIV   = 2,
   parameter int TI_LINE     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   cp0_timer_int_if.slave       wr,
   input  logic [5:0]           hw_int,
   output logic [31:0]          count,
   output logic [31:0]          compare,
   output logic                 ti,
   output logic [5:0]           ext_int
);

   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [31:0]      count_q, count_d;
   logic [31:0]      compare_q, compare_d;
   logic             ti_q, ti_d;
   logic [5:0]       sync_q [SYNC_STAGES];

   logic count_wr;
   logic compare_wr;
   logic inc;
   logic count_chg;

   always_comb begin
      count_wr   = wr.wr_en && (wr.wr_num == 5'd9)  && (wr.wr_sel == 3'd0);
      compare_wr = wr.wr_en && (wr.wr_num == 5'd11) && (wr.wr_sel == 3'd0);
      inc        = (div_cnt_q == DIV_LAST);

      div_cnt_d  = inc ? '0 : div_cnt_q + 1'b1;
      count_d    = count_q;
      count_chg  = 1'b0;
      // A Count write restarts the prescaler and swallows a coincident tick.
      if (count_wr) begin
         count_d   = wr.wr_data;
         div_cnt_d = '0;
         count_chg = 1'b1;
      end else if (inc) begin
         count_d   = count_q + 32'd1;
         count_chg = 1'b1;
      end

      compare_d = compare_wr ? wr.wr_data : compare_q;

      // Match only when Count moves onto Compare (old Compare value), so a
      // stationary equality such as 0==0 after reset never fires. A Compare
      // write acknowledges the interrupt and wins over a same-edge match.
      ti_d = ti_q;
      if (compare_wr) begin
         ti_d = 1'b0;
      end else if (count_chg && (count_d == compare_q)) begin
         ti_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q <= '0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         div_cnt_q <= div_cnt_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
         sync_q[0] <= hw_int;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign count   = count_q;
   assign compare = compare_q;
   assign ti      = ti_q;

   always_comb begin
      ext_int          = sync_q[SYNC_STAGES-1];
      ext_int[TI_LINE] = sync_q[SYNC_STAGES-1][TI_LINE] | ti_q;
   end

endmodule

// File: doc/cp0_timer_int.md
Name: cp0_timer_int

Overview:
- Interrupt-source front end sitting directly upstream of the CP0 register file.
- Owns the Count/Compare timer and synchronizes the six asynchronous hardware interrupt lines.
- Merges the timer interrupt into one line and drives the 6-bit pending vector that CP0 latches into Cause.IP[7:2].
- MTC0 writes to Count (reg 9) and Compare (reg 11) are routed here. CP0 reads count/compare back from this block.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages on each hw_int line (legal values 2..4).
- COUNT_DIV, 2, core clock cycles per Count increment (legal values >=1).
- TI_LINE, 5, index in ext_int that the timer interrupt is ORed onto (legal values 0..5).

Ports:
- clk  input  1  core clock. All state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- hw_int  input  6  asynchronous external interrupt requests, level-sensitive, active-high.
- wr_en  input  1  MTC0 commit strobe, one cycle per committed write.
- wr_num  input  5  CP0 register number of the write.
- wr_sel  input  3  CP0 select field of the write.
- wr_data  input  32  write data.
- count  output  32  current Count register.
- compare  output  32  current Compare register.
- ti  output  1  timer interrupt pending, sticky.
- ext_int  output  6  pending interrupt vector to CP0.

Behaviour:
- Reset: one clock is synchronous, reset is synchronous active-high. On a rising clk edge with rst=1:
  - count=0, compare=0, ti=0.
  - All synchronizer stages = 0, divider counter = 0.
  - Therefore ext_int=0 in the cycle after the reset edge.
  - rst dominates every other input, including a same-cycle write. Reset mid-count discards all state.
- Divider:
  - div_cnt counts 0..COUNT_DIV-1 and wraps.
  - An increment event occurs on the edge where div_cnt==COUNT_DIV-1.
  - With COUNT_DIV=1, count increments every cycle.
  - With the default of 2, the first increment after reset lands on the 2nd edge after rst deasserts.
- Count:
  - On an increment event, count <= count+1, modulo 2^32: 0xFFFFFFFF wraps to 0x00000000 with no flag.
  - Write hit: wr_en=1, wr_num=9, wr_sel=0 gives count <= wr_data and div_cnt <= 0.
  - A write beats a same-cycle increment; the increment is lost.
- Compare:
  - Write hit: wr_en=1, wr_num=11, wr_sel=0 gives compare <= wr_data and ti <= 0.
- Writes with any other wr_num, or with wr_sel!=0, are ignored.
- Timer match:
  - Let next_count be the value count takes at this edge.
  - If count changes at this edge (increment or Count write) and next_count==compare, then ti <= 1 at the same edge.
  - ti is therefore visible in the same cycle that count first equals compare.
  - A stationary equality does not re-trigger ti. In particular, count=compare=0 after reset does not set ti.
  - The comparison uses compare's value before the edge.
  - ti is sticky until a Compare write or reset.
  - A Compare write in the same cycle as a match leaves ti=0 (clear dominates).
  - Writing Count to exactly equal compare sets ti.
- External interrupts:
  - Each hw_int bit passes through SYNC_STAGES flops. No edge detection; the lines are level-sensitive.
  - Latency from a hw_int change to ext_int is SYNC_STAGES edges.
  - Deassertion follows with the same latency.
  - Clearing the interrupt is the device's responsibility.
- Output merge:
  - ext_int[i] = sync_last[i] for i != TI_LINE.
  - ext_int[TI_LINE] = sync_last[TI_LINE] | ti.
  - This OR is combinational from registers; there are no other combinational input-to-output paths.
- count, compare and ti are pure register outputs.
- Masking (IM/IE/EXL) is not done here. The block never looks at pipeline stall; the timer runs during stalls and exceptions.

Test Plan:
- Reset then idle 10 cycles, COUNT_DIV=2 -> count=5, ti=0, ext_int=0.
- Write Compare=0x20, then let count run from 0 -> on the edge where count becomes 0x20, ti=1 and ext_int=6'b100000. ti stays 1 while count keeps incrementing.
- With ti=1, write Compare=0x100 -> ti=0 next cycle. Also write Compare in the same cycle a match occurs -> ti stays 0.
- Write Count=0xFFFFFFFE with compare=0x00000000 -> after 2 increments count=0, ti=1. After 1 more increment count=1, ti=1 (sticky).
- Pulse hw_int=6'b000011 high for 5 cycles, SYNC_STAGES=2 -> ext_int=6'b000011 from 2 edges after assertion until 2 edges after deassertion. Assert hw_int[5] while ti=1 -> ext_int[5] stays 1 continuously.
- Assert rst for one cycle mid-run, with count=0x1234, ti=1, hw_int=6'h3F, and a concurrent Count write -> next cycle count=0, compare=0, ti=0, ext_int=0. The write is discarded.
